meas_sched: RTL
===============

# meas_sched

Measurement scheduler that repeatedly sequences the transmit and receive stages of the detection datapath. It issues `enTx`/`enRe` as one enable per phase and waits for the `overTx`/`overRe` completion handshakes. It measures echo time-of-flight in `clk_100` cycles and spaces shots on a fixed repetition period. It sits between the key/start logic and the TX/RE engines, and adds phase timeouts, shot counting and abort.

## Interface
- `PERIOD_CYC`, 1_000_000: shot repetition period in cycles, counted from TX entry (10 ms at 100 MHz).
- `TX_TIMEOUT`, 10_000: maximum cycles allowed in TX before abort.
- `RE_TIMEOUT`, 500_000: maximum cycles allowed in RE before abort.
- `TOF_W`, 20: time-of-flight counter/result width.
- `clk_100`  in  1  system clock, 100 MHz; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a burst; ignored while busy.
- `stop`  in  1  one-cycle abort; returns to IDLE from any state.
- `shots`  in  4  burst length, latched at start; 0 = continuous until stop.
- `enTx`  out  1  TX engine enable, level, high throughout TX.
- `overTx`  in  1  TX engine done, sampled only in TX.
- `enRe`  out  1  RE engine enable, level, high throughout RE.
- `overRe`  in  1  RE engine done, sampled only in RE.
- `echo`  in  1  echo detect pulse from receiver, sampled only in RE.
- `busy`  out  1  high in any state other than IDLE.
- `tof`  out  TOF_W  last captured time-of-flight; holds until next update.
- `tof_valid`  out  1  one-cycle pulse, `tof` updated.
- `err_timeout`  out  1  one-cycle pulse on TX or RE timeout.
- `shot_cnt`  out  4  shots completed in current burst (wraps mod 16).

## Operation
- States: IDLE, TX, RE, WAIT, one-hot. `enTx` = TX bit, `enRe` = RE bit, `busy` = !IDLE, all straight from state flops.
- IDLE: `start` && !`stop` -> TX. On this transition, latch `shots`, clear `shot_cnt`, and clear the period counter.
- TX: phase counter counts from 0.
  - `overTx` -> RE.
  - Otherwise, phase counter == TX_TIMEOUT-1 -> pulse `err_timeout`, go to WAIT.
  - Both in the same cycle: `overTx` wins.
- RE: phase counter cleared on entry. TOF counter = 0 in the first RE cycle, +1 per cycle, saturating at all-ones.
  - The first `echo` captures the TOF counter into the capture register; later echoes are ignored.
  - `overRe` -> `tof` <= captured value, or all-ones if no echo was seen; pulse `tof_valid`; go to WAIT.
  - `echo` and `overRe` in the same cycle: the echo is captured and used.
  - Phase counter == RE_TIMEOUT-1 without `overRe` -> pulse `err_timeout`, no `tof_valid`, go to WAIT.
- Shot completion: every exit from TX-by-timeout or from RE increments `shot_cnt`.
- WAIT: exit when the period counter >= PERIOD_CYC-1.
  - If latched shots != 0 and `shot_cnt` == latched shots -> IDLE.
  - Otherwise -> TX, and clear the period counter.
- Period counter: runs in TX/RE/WAIT and saturates. If TX+RE already exceeded the period, WAIT lasts exactly one cycle.
- `stop`: in any state -> IDLE next edge. Both enables drop, no `tof_valid`/`err_timeout` pulse that cycle, and `tof`/`shot_cnt` are held.
- `start` while busy: ignored.

## Timing
- Reset values: state IDLE, `enTx`=0, `enRe`=0, `busy`=0, `tof`=0, `tof_valid`=0, `err_timeout`=0, `shot_cnt`=0, all counters 0.
- Reset mid-burst: everything returns to these values asynchronously, with no pulses.
- `start` sampled at edge N -> `enTx`/`busy` high after edge N.
- `overTx` high at edge M -> after edge M, `enTx`=0 and `enRe`=1 on the same edge. There is no gap cycle and no overlap.
- `overRe` high at edge K -> after edge K, `enRe`=0; `tof_valid`=1 and the new `tof` are present for exactly one cycle.
- `tof` value = number of RE cycles before the echo cycle. Echo in the first RE cycle -> 0.
- Minimum shot spacing: TX entry to next TX entry = max(PERIOD_CYC, TX+RE cycles + 1).
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Single shot: shots=1, start; `overTx` 5 cycles after `enTx` rises; `echo` at RE cycle 37; `overRe` at RE cycle 100 -> `tof_valid` pulse with `tof`=37, `shot_cnt`=1, IDLE after PERIOD_CYC-1 cycles of period, `busy` low.
- No echo: same as above without `echo` -> `tof`=2^TOF_W-1 and `tof_valid` pulses once.
- TX timeout: shots=2, `overTx` never asserted -> `err_timeout` pulse at TX cycle TX_TIMEOUT-1, WAIT, then a second TX; after two timeouts `shot_cnt`=2 and state IDLE; `enRe` never rises.
- Continuous and stop: shots=0, normal handshakes for 3 periods, then `stop` mid-RE -> `enRe` low next cycle, no `tof_valid`, `shot_cnt`=3 held; a later `start` begins a new burst with `shot_cnt`=0.
- Corner cases: `echo` and `overRe` in the same cycle -> that echo is captured. `start` while busy -> no effect. `start`+`stop` together in IDLE -> remains IDLE.
- Async `rst` asserted mid-TX -> `enTx`=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/meas_sched_if.sv
// Measurement scheduler bus: burst control from the key/start logic, enable/done
// handshakes with the TX and RE engines, and the scheduler's result outputs.
//   master : scheduler side (drives enables, status and results)
//   slave  : environment side (drives start/stop/shots, engine done and echo)
interface meas_sched_if #(
    parameter int unsigned TOF_W = 20
) ();
    logic             start;
    logic             stop;
    logic [3:0]       shots;
    logic             enTx;
    logic             overTx;
    logic             enRe;
    logic             overRe;
    logic             echo;
    logic             busy;
    logic [TOF_W-1:0] tof;
    logic             tof_valid;
    logic             err_timeout;
    logic [3:0]       shot_cnt;

    modport master (
        input  start, stop, shots, overTx, overRe, echo,
        output enTx, enRe, busy, tof, tof_valid, err_timeout, shot_cnt
    );

    modport slave (
        output start, stop, shots, overTx, overRe, echo,
        input  enTx, enRe, busy, tof, tof_valid, err_timeout, shot_cnt
    );
endinterface

// File: rtl/meas_sched.sv
// Measurement scheduler: sequences TX then RE once per shot, measures echo
// time-of-flight in clk_100 cycles, spaces shots on a fixed period, and adds
// phase timeouts, shot counting and abort.
//   clk_100 : system clock
//   rst     : asynchronous active-high reset
//   bus     : meas_sched_if.master (start/stop/shots in, engine handshakes,
//             busy/tof/tof_valid/err_timeout/shot_cnt out; all outputs registered)
module meas_sched #(
    parameter int unsigned PERIOD_CYC = 1_000_000,
    parameter int unsigned TX_TIMEOUT = 10_000,
    parameter int unsigned RE_TIMEOUT = 500_000,
    parameter int unsigned TOF_W      = 20
) (
    input  logic         clk_100,
    input  logic         rst,
    meas_sched_if.master bus
);
    localparam int unsigned PH_MAX = (TX_TIMEOUT > RE_TIMEOUT) ? TX_TIMEOUT : RE_TIMEOUT;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned PER_W  = $clog2(PERIOD_CYC + 1);

    localparam logic [PH_W-1:0]  TX_LAST  = PH_W'(TX_TIMEOUT - 1);
    localparam logic [PH_W-1:0]  RE_LAST  = PH_W'(RE_TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
    localparam logic [TOF_W-1:0] TOF_MAX  = '1;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StTx   = 4'b0010,
        StRe   = 4'b0100,
        StWait = 4'b1000
    } state_e;

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PER_W-1:0] period_q, period_d, period_inc;
    logic [TOF_W-1:0] tof_cnt_q, tof_cnt_d;
    logic [TOF_W-1:0] cap_q, cap_d;
    logic [TOF_W-1:0] tof_q, tof_d;
    logic             echo_seen_q, echo_seen_d;
    logic [3:0]       shots_q, shots_d;
    logic [3:0]       shot_cnt_q, shot_cnt_d;
    logic             tof_valid_q, tof_valid_d;
    logic             err_q, err_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        period_d    = period_q;
        tof_cnt_d   = tof_cnt_q;
        cap_d       = cap_q;
        tof_d       = tof_q;
        echo_seen_d = echo_seen_q;
        shots_d     = shots_q;
        shot_cnt_d  = shot_cnt_q;
        tof_valid_d = 1'b0;
        err_d       = 1'b0;

        // Saturating: once past the period, WAIT only needs to see "elapsed".
        period_inc = (period_q >= PER_LAST) ? period_q : period_q + 1'b1;

        if (bus.stop) begin
            // Abort wins over everything; results and shot count are held.
            state_d = StIdle;
            phase_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d    = StTx;
                        shots_d    = bus.shots;
                        shot_cnt_d = '0;
                        period_d   = '0;
                        phase_d    = '0;
                    end
                end
                StTx: begin
                    period_d = period_inc;
                    phase_d  = phase_q + 1'b1;
                    if (bus.overTx) begin
                        state_d     = StRe;
                        phase_d     = '0;
                        tof_cnt_d   = '0;
                        echo_seen_d = 1'b0;
                    end else if (phase_q == TX_LAST) begin
                        state_d    = StWait;
                        phase_d    = '0;
                        err_d      = 1'b1;
                        shot_cnt_d = shot_cnt_q + 1'b1;
                    end
                end
                StRe: begin
                    period_d  = period_inc;
                    phase_d   = phase_q + 1'b1;
                    tof_cnt_d = (tof_cnt_q == TOF_MAX) ? tof_cnt_q : tof_cnt_q + 1'b1;
                    if (bus.echo && !echo_seen_q) begin
                        echo_seen_d = 1'b1;
                        cap_d       = tof_cnt_q;
                    end
                    if (bus.overRe) begin
                        state_d     = StWait;
                        phase_d     = '0;
                        tof_valid_d = 1'b1;
                        shot_cnt_d  = shot_cnt_q + 1'b1;
                        // An echo arriving with overRe still counts.
                        if (echo_seen_q)   tof_d = cap_q;
                        else if (bus.echo) tof_d = tof_cnt_q;
                        else               tof_d = TOF_MAX;
                    end else if (phase_q == RE_LAST) begin
                        state_d    = StWait;
                        phase_d    = '0;
                        err_d      = 1'b1;
                        shot_cnt_d = shot_cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    period_d = period_inc;
                    if (period_q >= PER_LAST) begin
                        if (shots_q != 4'd0 && shot_cnt_q == shots_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d  = StTx;
                            period_d = '0;
                            phase_d  = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            period_q    <= '0;
            tof_cnt_q   <= '0;
            cap_q       <= '0;
            tof_q       <= '0;
            echo_seen_q <= 1'b0;
            shots_q     <= '0;
            shot_cnt_q  <= '0;
            tof_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            tof_cnt_q   <= tof_cnt_d;
            cap_q       <= cap_d;
            tof_q       <= tof_d;
            echo_seen_q <= echo_seen_d;
            shots_q     <= shots_d;
            shot_cnt_q  <= shot_cnt_d;
            tof_valid_q <= tof_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.enTx        = (state_q == StTx);
    assign bus.enRe        = (state_q == StRe);
    assign bus.busy        = (state_q != StIdle);
    assign bus.tof         = tof_q;
    assign bus.tof_valid   = tof_valid_q;
    assign bus.err_timeout = err_q;
    assign bus.shot_cnt    = shot_cnt_q;
endmodule
